// File: rtl/insert_frame_length.sv
// Store-and-forward framer: buffers each input frame, counts its bytes, and
// replays it prefixed by a big-endian length header once the frame is complete.
module insert_frame_length #(
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned FRAME_LENGTH_WIDTH = 16,
    parameter int unsigned BUFFER_DEPTH       = 2048,
    parameter int unsigned LENGTH_FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int unsigned HDR_BEATS      = FRAME_LENGTH_WIDTH / DATA_WIDTH;
    localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int unsigned AW             = $clog2(BUFFER_DEPTH);
    localparam int unsigned LAW            = $clog2(LENGTH_FIFO_DEPTH);
    localparam int unsigned HIW            = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

    typedef enum logic [1:0] {StIdle, StHeader, StBody} state_e;

    // Frame data buffer: each entry is {tlast, data}
    logic [DATA_WIDTH:0]         buf_mem [BUFFER_DEPTH];
    logic [AW-1:0]               buf_wr_q, buf_rd_q;
    logic [AW:0]                 buf_cnt_q;
    logic                        buf_full, buf_empty, buf_rd;

    // Completed-frame length FIFO
    logic [FRAME_LENGTH_WIDTH-1:0] lf_mem [LENGTH_FIFO_DEPTH];
    logic [LAW-1:0]              lf_wr_q, lf_rd_q, lf_rd_nxt;
    logic [LAW:0]                lf_cnt_q;
    logic                        lf_full, lf_empty, lf_push, lf_pop;

    logic [FRAME_LENGTH_WIDTH-1:0] byte_cnt_q, byte_cnt_d, byte_inc;
    logic [FRAME_LENGTH_WIDTH:0]   byte_sum;
    logic                        ready_en_q, in_fire;

    state_e                      state_q, state_d;
    logic [HIW-1:0]              hdr_idx_q, hdr_idx_d;
    logic                        out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic                        out_fire, out_free;

    // Header beat idx of a length, most-significant beat first
    function automatic logic [DATA_WIDTH-1:0] hdr_beat(input logic [FRAME_LENGTH_WIDTH-1:0] len,
                                                       input int unsigned idx);
        logic [FRAME_LENGTH_WIDTH-1:0] sh;
        sh = len >> ((HDR_BEATS - 1 - idx) * DATA_WIDTH);
        return sh[DATA_WIDTH-1:0];
    endfunction

    assign buf_full  = (buf_cnt_q == (AW+1)'(BUFFER_DEPTH));
    assign buf_empty = (buf_cnt_q == '0);
    assign lf_full   = (lf_cnt_q == (LAW+1)'(LENGTH_FIFO_DEPTH));
    assign lf_empty  = (lf_cnt_q == '0);
    assign lf_rd_nxt = lf_rd_q + LAW'(1);

    // ready_en_q keeps tready low during reset and for the cycle it releases
    assign s_axis_tready = ready_en_q & ~buf_full & ~lf_full;
    assign in_fire       = s_axis_tvalid & s_axis_tready;
    assign lf_push       = in_fire & s_axis_tlast;

    assign out_fire      = out_valid_q & m_axis_tready;
    assign out_free      = ~out_valid_q | m_axis_tready;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;

    // Saturating per-frame byte counter; the pushed length includes the tlast beat
    always_comb begin
        byte_sum   = {1'b0, byte_cnt_q} + (FRAME_LENGTH_WIDTH+1)'(BYTES_PER_BEAT);
        byte_inc   = byte_sum[FRAME_LENGTH_WIDTH] ? '1 : byte_sum[FRAME_LENGTH_WIDTH-1:0];
        byte_cnt_d = byte_cnt_q;
        if (in_fire) begin
            byte_cnt_d = s_axis_tlast ? '0 : byte_inc;
        end
    end

    // Storage arrays need no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_mem[buf_wr_q] <= {s_axis_tlast, s_axis_tdata};
        end
        if (lf_push) begin
            lf_mem[lf_wr_q] <= byte_inc;
        end
    end

    // Input side: buffer pointers, occupancy and byte counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en_q <= 1'b0;
            byte_cnt_q <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            buf_cnt_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            byte_cnt_q <= byte_cnt_d;
            if (in_fire) buf_wr_q <= buf_wr_q + AW'(1);
            if (buf_rd)  buf_rd_q <= buf_rd_q + AW'(1);
            case ({in_fire, buf_rd})
                2'b10:   buf_cnt_q <= buf_cnt_q + (AW+1)'(1);
                2'b01:   buf_cnt_q <= buf_cnt_q - (AW+1)'(1);
                default: buf_cnt_q <= buf_cnt_q;
            endcase
        end
    end

    // Length FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lf_wr_q  <= '0;
            lf_rd_q  <= '0;
            lf_cnt_q <= '0;
        end else begin
            if (lf_push) lf_wr_q <= lf_wr_q + LAW'(1);
            if (lf_pop)  lf_rd_q <= lf_rd_nxt;
            case ({lf_push, lf_pop})
                2'b10:   lf_cnt_q <= lf_cnt_q + (LAW+1)'(1);
                2'b01:   lf_cnt_q <= lf_cnt_q - (LAW+1)'(1);
                default: lf_cnt_q <= lf_cnt_q;
            endcase
        end
    end

    // Output FSM: state names what the output register currently holds;
    // the register is refilled whenever it is empty or being accepted
    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        out_valid_d = out_valid_q & ~m_axis_tready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        buf_rd      = 1'b0;
        lf_pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!lf_empty && out_free) begin
                    state_d     = StHeader;
                    hdr_idx_d   = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_data_d  = hdr_beat(lf_mem[lf_rd_q], 0);
                end
            end
            StHeader: begin
                if (out_fire) begin
                    if (hdr_idx_q == HIW'(HDR_BEATS - 1)) begin
                        state_d = StBody;
                        if (!buf_empty) begin
                            buf_rd                   = 1'b1;
                            out_valid_d              = 1'b1;
                            {out_last_d, out_data_d} = buf_mem[buf_rd_q];
                        end
                    end else begin
                        hdr_idx_d   = hdr_idx_q + HIW'(1);
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        out_data_d  = hdr_beat(lf_mem[lf_rd_q], 32'(hdr_idx_d));
                    end
                end
            end
            StBody: begin
                if (out_fire && out_last_q) begin
                    lf_pop = 1'b1;
                    // Next length is already queued: start its header with no gap
                    if (lf_cnt_q > (LAW+1)'(1)) begin
                        state_d     = StHeader;
                        hdr_idx_d   = '0;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        out_data_d  = hdr_beat(lf_mem[lf_rd_nxt], 0);
                    end else begin
                        state_d = StIdle;
                    end
                end else if (out_free && !buf_empty) begin
                    buf_rd                   = 1'b1;
                    out_valid_d              = 1'b1;
                    {out_last_d, out_data_d} = buf_mem[buf_rd_q];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register and FSM state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            hdr_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_insert_frame_length.sv
// Bench for insert_frame_length: random frames against a header+payload stream model.
module tb_insert_frame_length;

    localparam int DW  = 8;
    localparam int BD  = 2048;
    localparam int TMO = 5000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;

    int            n_run = 0;
    int            n_fail = 0;
    logic [7:0]    fb [0:BD-1];
    logic [8:0]    exp_q [$];
    logic [8:0]    got_q [$];
    int unsigned   got_cyc [$];
    int unsigned   cyc = 0;

    insert_frame_length #(
        .DATA_WIDTH(DW),
        .FRAME_LENGTH_WIDTH(16),
        .BUFFER_DEPTH(BD),
        .LENGTH_FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture accepted output beats half a cycle before the accepting edge
    always @(negedge clk) begin
        if (rstn && m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tlast, m_axis_tdata});
            got_cyc.push_back(cyc);
        end
    end

    // Reference: a frame of n bytes appears as len[15:8], len[7:0], then the bytes
    function automatic void model_push(input int len);
        logic [15:0] l16;
        l16 = 16'(len);
        exp_q.push_back({1'b0, l16[15:8]});
        exp_q.push_back({1'b0, l16[7:0]});
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), fb[i]});
    endfunction

    function automatic void fill_random(input int len);
        for (int i = 0; i < len; i++) fb[i] = 8'($urandom_range(255));
    endfunction

    function automatic void clear_all();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endfunction

    // Drive fb[0..len-1]; called and returns at posedge+1
    task automatic drive_beats(input int len, input bit end_frame, input int gap_pct);
        int w;
        for (int i = 0; i < len; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fb[i];
            s_axis_tlast  = end_frame && (i == len - 1);
            w = 0;
            @(negedge clk);
            while (!s_axis_tready && w < TMO) begin
                w++;
                @(negedge clk);
            end
            if (w >= TMO) begin
                n_run++;
                n_fail++;
                $display("FAIL drive_timeout beat %0d: s_axis_tready=0, required 1", i);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < lim) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_run += 4;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b, want 0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b, want 0", m_axis_tlast); end
        if (m_axis_tdata !== 8'h00) begin n_fail++; $display("FAIL rst_tdata: got %02h, want 00", m_axis_tdata); end
        if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b, want 0", s_axis_tready); end
        #2 rstn = 1'b1;
        #1;
        n_run++;
        if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rel_tready_early: got %b, want 0", s_axis_tready); end
        @(posedge clk);
        @(negedge clk);
        n_run++;
        if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rel_tready_rise: got %b, want 1", s_axis_tready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int lat;
        clear_all();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 60; i++) fb[i] = 8'(i + 1);
        model_push(60);
        drive_beats(60, 1'b1, 0);
        lat = 0;
        @(negedge clk);
        while (!m_axis_tvalid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_run++;
        if (lat < 1 || lat > 2) begin n_fail++; $display("FAIL single_latency: got %0d cycles, want 1..2", lat); end
        wait_drain(500);
        n_run++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d beats, want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_run++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_beat[%0d]: got %03h, want %03h", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_min_frame();
        clear_all();
        m_axis_tready = 1'b1;
        fb[0] = 8'hA5;
        model_push(1);
        drive_beats(1, 1'b1, 0);
        wait_drain(100);
        repeat (5) @(posedge clk);
        n_run++;
        if (got_q.size() != 3) begin n_fail++; $display("FAIL min_count: got %0d beats, want 3", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_run++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL min_beat[%0d]: got %03h, want %03h", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_all();
        m_axis_tready = 1'b0;
        fill_random(64);
        model_push(64);
        drive_beats(64, 1'b1, 0);
        fill_random(1518);
        model_push(1518);
        drive_beats(1518, 1'b1, 0);
        m_axis_tready = 1'b1;
        wait_drain(3000);
        n_run++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d beats, want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_run++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat[%0d]: got %03h, want %03h", i, got_q[i], exp_q[i]); end
        end
        gap = (got_cyc.size() > 66) ? int'(got_cyc[66] - got_cyc[65]) - 1 : 99;
        n_run++;
        if (gap > 1) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles, want <=1", gap); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit         drv_done = 1'b0;
        bit         bp_done = 1'b0;
        int         t = 0;
        int         len;
        logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [7:0] pd = '0;
        clear_all();
        m_axis_tready = 1'b0;
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    len = $urandom_range(50, 1);
                    fill_random(len);
                    model_push(len);
                    drive_beats(len, 1'b1, 30);
                end
                drv_done = 1'b1;
            end
            begin
                repeat (50) @(posedge clk);
                #1;
                while (!(drv_done && got_q.size() >= exp_q.size()) && t < 20000) begin
                    @(posedge clk); #1;
                    m_axis_tready = 1'($urandom_range(1));
                    t++;
                end
                m_axis_tready = 1'b1;
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(negedge clk);
                    if (pv && !pr) begin
                        n_run++;
                        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {pv, pl, pd}) begin
                            n_fail++;
                            $display("FAIL bp_stable: got v=%b l=%b d=%02h, want v=%b l=%b d=%02h",
                                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, pv, pl, pd);
                        end
                    end
                    pv = m_axis_tvalid;
                    pr = m_axis_tready;
                    pl = m_axis_tlast;
                    pd = m_axis_tdata;
                end
            end
        join
        n_run++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d beats, want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_run++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat[%0d]: got %03h, want %03h", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fifo_full();
        logic want;
        clear_all();
        m_axis_tready = 1'b0;
        for (int f = 0; f < 8; f++) begin
            fill_random(2);
            model_push(2);
            drive_beats(2, 1'b1, 0);
            if (f >= 6) begin
                @(negedge clk);
                want = (f == 6);
                n_run++;
                if (s_axis_tready !== want) begin n_fail++; $display("FAIL lfifo_tready after %0d frames: got %b, want %b", f + 1, s_axis_tready, want); end
                @(posedge clk); #1;
            end
        end
        fork
            begin
                fill_random(2);
                model_push(2);
                drive_beats(2, 1'b1, 0);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        wait_drain(500);
        n_run++;
        if (got_q.size() != 36) begin n_fail++; $display("FAIL lfifo_count: got %0d beats, want 36", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_run++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lfifo_beat[%0d]: got %03h, want %03h", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_buffer_full();
        clear_all();
        m_axis_tready = 1'b0;
        fill_random(BD);
        model_push(BD);
        drive_beats(BD, 1'b1, 0);
        @(negedge clk);
        n_run++;
        if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL buf_full_tready: got %b, want 0", s_axis_tready); end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        wait_drain(6000);
        n_run++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL buf_count: got %0d beats, want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_run++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL buf_beat[%0d]: got %03h, want %03h", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int t = 0;
        clear_all();
        m_axis_tready = 1'b1;
        fill_random(30);
        drive_beats(30, 1'b1, 0);
        fill_random(5);
        drive_beats(5, 1'b0, 0);
        while (got_q.size() < 10 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #3 rstn = 1'b0;
        #1;
        n_run += 4;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid: got %b, want 0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL midrst_tlast: got %b, want 0", m_axis_tlast); end
        if (m_axis_tdata !== 8'h00) begin n_fail++; $display("FAIL midrst_tdata: got %02h, want 00", m_axis_tdata); end
        if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_tready: got %b, want 0", s_axis_tready); end
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        clear_all();
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) fb[i] = 8'($urandom_range(255));
        model_push(10);
        drive_beats(10, 1'b1, 0);
        wait_drain(200);
        repeat (20) @(posedge clk);
        n_run++;
        if (got_q.size() != 12) begin n_fail++; $display("FAIL midrst_count: got %0d beats, want 12", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_run++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_beat[%0d]: got %03h, want %03h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_min_frame();
        test_back_to_back();
        test_backpressure();
        test_fifo_full();
        test_buffer_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
